// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the instruction sequencer.
//   seq_state_e   : 3-bit state encodings SEQ_FETCH .. SEQ_WB
//   ALU_UDV/SDV   : decoder alu_op codes of the multi-cycle divide operations
//   dec_lat_t     : decoder fields captured in DECODE
//   seq_out_t     : registered output bundle of the sequencer
//   is_multicycle: true for ALU ops that use the start/done handshake
package instr_sequencer_pkg;

  typedef enum logic [2:0] {
    SEQ_FETCH    = 3'd0,
    SEQ_DECODE   = 3'd1,
    SEQ_EXEC     = 3'd2,
    SEQ_ALU_WAIT = 3'd3,
    SEQ_ATC_REQ  = 3'd4,
    SEQ_ATC_TEST = 3'd5,
    SEQ_ATC_CLR  = 3'd6,
    SEQ_WB       = 3'd7
  } seq_state_e;

  localparam logic [4:0] ALU_UDV = 5'h0C;
  localparam logic [4:0] ALU_SDV = 5'h0D;

  typedef struct packed {
    logic we;
    logic br;
    logic atc;
  } dec_lat_t;

  typedef struct packed {
    logic fetch_req;
    logic alu_start;
    logic atc_req;
    logic atc_lock;
    logic atc_clear;
    logic reg_we;
    logic ip_inc;
    logic ip_load;
    logic busy;
  } seq_out_t;

  function automatic logic is_multicycle(input logic [4:0] op);
    return (op == ALU_UDV) || (op == ALU_SDV);
  endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Handshake/bus signals between the sequencer and the rest of the core.
//   master : sequencer side (drives fetch/ALU/ATC/writeback strobes)
//   slave  : core side (fetch unit, decoder, ALU, flag arbiter)
// Signals:
//   fetch_req / instr_valid                      : instruction fetch
//   write_enable_in, branch_select_in, is_atc_in,
//   alu_op_in                                    : decoder outputs
//   alu_start / alu_done, cond_true              : ALU
//   atc_req / atc_gnt / atc_flag / atc_lock /
//   atc_clear                                    : shared flag access
//   reg_we, ip_inc, ip_load                      : writeback strobes
//   alu_timeout, busy                            : status
interface instr_sequencer_if;
  logic       fetch_req;
  logic       instr_valid;
  logic       write_enable_in;
  logic       branch_select_in;
  logic       is_atc_in;
  logic [4:0] alu_op_in;
  logic       alu_start;
  logic       alu_done;
  logic       cond_true;
  logic       atc_req;
  logic       atc_gnt;
  logic       atc_flag;
  logic       atc_lock;
  logic       atc_clear;
  logic       reg_we;
  logic       ip_inc;
  logic       ip_load;
  logic       alu_timeout;
  logic       busy;

  modport master (
    output fetch_req, alu_start, atc_req, atc_lock, atc_clear,
           reg_we, ip_inc, ip_load, alu_timeout, busy,
    input  instr_valid, write_enable_in, branch_select_in, is_atc_in,
           alu_op_in, alu_done, cond_true, atc_gnt, atc_flag
  );

  modport slave (
    input  fetch_req, alu_start, atc_req, atc_lock, atc_clear,
           reg_we, ip_inc, ip_load, alu_timeout, busy,
    output instr_valid, write_enable_in, branch_select_in, is_atc_in,
           alu_op_in, alu_done, cond_true, atc_gnt, atc_flag
  );
endinterface

// File: rtl/instr_sequencer_alu_watchdog.sv
// alu_watchdog: counts cycles spent waiting on a multi-cycle ALU op.
//   clk     : clock
//   enable  : count this cycle (sequencer is in ALU_WAIT)
//   clear   : synchronous clear, dominates enable
//   expired : count has reached ALU_TIMEOUT
// The counter saturates at ALU_TIMEOUT so it can never wrap back below it.
module alu_watchdog #(
  parameter int ALU_TIMEOUT = 64,
  parameter int TO_W        = 7
) (
  input  logic clk,
  input  logic enable,
  input  logic clear,
  output logic expired
);

  localparam logic [TO_W-1:0] LIMIT = TO_W'(ALU_TIMEOUT);

  logic [TO_W-1:0] cnt;

  assign expired = (cnt >= LIMIT);

  always_ff @(posedge clk) begin
    if (clear)                   cnt <= '0;
    else if (enable && !expired) cnt <= cnt + TO_W'(1);
  end

endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle fetch/decode/execute/writeback sequencer.
// Gates the decoder's write_enable/branch_select/is_atc into single-cycle
// strobes, stalls on divide behind alu_start/alu_done with a watchdog, and
// runs the atomic test-and-clear as a locked access to the shared flag.
// Ports:
//   clk   : clock
//   reset : synchronous, active-high
//   step  : single-step pulse (only when SEQ_SINGLE_STEP_EN is defined)
//   bus   : instr_sequencer_if.master (fetch, decoder, ALU, ATC, WB strobes)
// Build option: define SEQ_SINGLE_STEP_EN to gate each fetch on a latched
// step pulse; undefined, FETCH requests unconditionally.
// Every output is a register loaded from the next-state decode, so outputs
// line up with the state they describe and carry no combinational paths.
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int ALU_TIMEOUT = 64,
  parameter int TO_W        = 7
) (
  input logic clk,
  input logic reset,
`ifdef SEQ_SINGLE_STEP_EN
  input logic step,
`endif
  instr_sequencer_if.master bus
);

  seq_state_e state, state_nxt;
  dec_lat_t   lat, lat_nxt;
  logic       take, take_nxt;
  logic       aborted, abort_nxt;
  logic       timeout_q, to_nxt;
  seq_out_t   out_q, out_d;
  logic       step_ok, step_ok_nxt;
  logic       expired;
  logic       wb_nxt;

`ifdef SEQ_SINGLE_STEP_EN
  logic step_lat, step_lat_nxt;
`endif

  alu_watchdog #(
    .ALU_TIMEOUT (ALU_TIMEOUT),
    .TO_W        (TO_W)
  ) u_wdog (
    .clk     (clk),
    .enable  (state == SEQ_ALU_WAIT),
    .clear   (reset || (state != SEQ_ALU_WAIT)),
    .expired (expired)
  );

  always_comb begin
    state_nxt = state;
    lat_nxt   = lat;
    take_nxt  = take;
    abort_nxt = aborted;
    to_nxt    = timeout_q;
    out_d     = '0;
`ifdef SEQ_SINGLE_STEP_EN
    step_ok   = step_lat;
`else
    step_ok   = 1'b1;
`endif

    unique case (state)
      SEQ_FETCH: begin
        if (bus.instr_valid && step_ok) state_nxt = SEQ_DECODE;
      end
      SEQ_DECODE: begin
        lat_nxt   = '{we: bus.write_enable_in, br: bus.branch_select_in,
                      atc: bus.is_atc_in};
        take_nxt  = 1'b0;
        abort_nxt = 1'b0;
        if (bus.is_atc_in) begin
          state_nxt = SEQ_ATC_REQ;
        end else if (is_multicycle(bus.alu_op_in)) begin
          state_nxt       = SEQ_ALU_WAIT;
          out_d.alu_start = 1'b1;
        end else begin
          state_nxt = SEQ_EXEC;
        end
      end
      SEQ_EXEC: begin
        take_nxt  = lat.br & bus.cond_true;
        state_nxt = SEQ_WB;
      end
      SEQ_ALU_WAIT: begin
        // done wins over a same-cycle expiry: the result is valid
        if (bus.alu_done) begin
          state_nxt = SEQ_WB;
        end else if (expired) begin
          abort_nxt = 1'b1;
          to_nxt    = 1'b1;
          state_nxt = SEQ_WB;
        end
      end
      SEQ_ATC_REQ: begin
        if (bus.atc_gnt) state_nxt = SEQ_ATC_TEST;
      end
      SEQ_ATC_TEST: begin
        // a grant dropped while locked is the arbiter's fault; carry on
        if (bus.atc_flag) begin
          state_nxt = SEQ_ATC_CLR;
        end else begin
          take_nxt  = 1'b0;
          state_nxt = SEQ_WB;
        end
      end
      SEQ_ATC_CLR: begin
        take_nxt  = 1'b1;
        state_nxt = SEQ_WB;
      end
      SEQ_WB: begin
        state_nxt = SEQ_FETCH;
      end
    endcase

`ifdef SEQ_SINGLE_STEP_EN
    // the latch is spent on leaving FETCH; a pulse in that same cycle
    // belongs to the next instruction
    step_lat_nxt = ((state == SEQ_FETCH) && (state_nxt != SEQ_FETCH)) ?
                   step : (step_lat | step);
    step_ok_nxt  = step_lat_nxt;
`else
    step_ok_nxt  = 1'b1;
`endif

    wb_nxt          = (state_nxt == SEQ_WB);
    out_d.fetch_req = (state_nxt == SEQ_FETCH) && step_ok_nxt;
    out_d.busy      = (state_nxt != SEQ_FETCH);
    out_d.atc_req   = (state_nxt == SEQ_ATC_REQ);
    out_d.atc_clear = (state_nxt == SEQ_ATC_CLR);
    // lock spans grant through the ATC's own writeback cycle
    out_d.atc_lock  = (state_nxt == SEQ_ATC_TEST) || (state_nxt == SEQ_ATC_CLR) ||
                      (wb_nxt && lat_nxt.atc);
    out_d.reg_we    = wb_nxt && lat_nxt.we && !lat_nxt.br && !lat_nxt.atc &&
                      !abort_nxt;
    out_d.ip_load   = wb_nxt && take_nxt;
    out_d.ip_inc    = wb_nxt && !take_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= SEQ_FETCH;
      lat       <= '0;
      take      <= 1'b0;
      aborted   <= 1'b0;
      timeout_q <= 1'b0;
      out_q     <= '0;
    end else begin
      state     <= state_nxt;
      lat       <= lat_nxt;
      take      <= take_nxt;
      aborted   <= abort_nxt;
      timeout_q <= to_nxt;
      out_q     <= out_d;
    end
  end

`ifdef SEQ_SINGLE_STEP_EN
  always_ff @(posedge clk) begin
    if (reset) step_lat <= 1'b0;
    else       step_lat <= step_lat_nxt;
  end
`endif

  assign bus.fetch_req   = out_q.fetch_req;
  assign bus.alu_start   = out_q.alu_start;
  assign bus.atc_req     = out_q.atc_req;
  assign bus.atc_lock    = out_q.atc_lock;
  assign bus.atc_clear   = out_q.atc_clear;
  assign bus.reg_we      = out_q.reg_we;
  assign bus.ip_inc      = out_q.ip_inc;
  assign bus.ip_load     = out_q.ip_load;
  assign bus.busy        = out_q.busy;
  assign bus.alu_timeout = timeout_q;

  a_wb_excl: assert property (@(posedge clk) !(out_q.ip_inc && out_q.ip_load));

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: a hand-computed vector table,
// hand-written reset/step sequences, then randomized instructions checked
// against a timing model derived from the per-instruction latency rules.
module tb_instr_sequencer;
  import instr_sequencer_pkg::*;

  localparam int T = 8;
`ifdef SEQ_SINGLE_STEP_EN
  localparam bit STEP_MODE = 1'b1;
`else
  localparam bit STEP_MODE = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic step_drv;

  instr_sequencer_if bus();

  instr_sequencer #(.ALU_TIMEOUT(T), .TO_W(4)) dut (
    .clk   (clk),
    .reset (reset),
`ifdef SEQ_SINGLE_STEP_EN
    .step  (step_drv),
`endif
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    string      name;
    logic       we, br, atc;
    logic [4:0] op;
    logic       cond, flag;
    int         d, g;          // done delay after alu_start, grant delay after atc_req
    int         e_off;         // WB cycle relative to instr_valid
    logic       e_we, e_load, e_clr, e_to;
  } vec_t;

  typedef struct {
    int wb_off, n_wb, n_clr, clr_off, n_start, start_off;
    int n_req, lock_first, n_lock, both, busy_gap, fetch_off;
    logic we, load, to;
  } obs_t;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0d expected=%0d", name, $signed(act), $signed(exp));
    end
  endtask

  function automatic logic [9:0] outs();
    return {bus.fetch_req, bus.alu_start, bus.atc_req, bus.atc_lock, bus.atc_clear,
            bus.reg_we, bus.ip_inc, bus.ip_load, bus.alu_timeout, bus.busy};
  endfunction

  task automatic clr_inputs();
    bus.instr_valid = 0; bus.write_enable_in = 0; bus.branch_select_in = 0;
    bus.is_atc_in = 0; bus.alu_op_in = '0; bus.alu_done = 0; bus.cond_true = 0;
    bus.atc_gnt = 0; bus.atc_flag = 0;
  endtask

  task automatic do_reset();
    reset = 1; step_drv = 0; clr_inputs();
    tick(); tick();
    reset = 0;
    tick();
  endtask

  function automatic vec_t mk(input string name, input logic we, br, atc,
                              input logic [4:0] op, input logic cond, flag,
                              input int d, g, e_off,
                              input logic e_we, e_load, e_clr, e_to);
    vec_t v;
    v.name = name; v.we = we; v.br = br; v.atc = atc; v.op = op;
    v.cond = cond; v.flag = flag; v.d = d; v.g = g; v.e_off = e_off;
    v.e_we = e_we; v.e_load = e_load; v.e_clr = e_clr; v.e_to = e_to;
    return v;
  endfunction

  function automatic bit is_div(input vec_t v);
    return !v.atc && (v.op == ALU_UDV || v.op == ALU_SDV);
  endfunction

  // Latency rules: simple 3 cycles; divide = start at +2, WB one after done
  // or at +3+T on timeout; ATC = request at +2, grant g later, test, optional
  // clear, WB. e_to here flags "this instruction times out".
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    r.e_clr = 0; r.e_to = 0; r.e_load = 0; r.e_we = 0;
    if (v.atc) begin
      r.e_off  = v.flag ? 5 + v.g : 4 + v.g;
      r.e_load = v.flag;
      r.e_clr  = v.flag;
    end else if (is_div(v)) begin
      if (v.d <= T) begin
        r.e_off = 3 + v.d;
        r.e_we  = v.we && !v.br;
      end else begin
        r.e_off = 3 + T;
        r.e_to  = 1;
      end
    end else begin
      r.e_off  = 3;
      r.e_load = v.br && v.cond;
      r.e_we   = v.we && !v.br;
    end
    return r;
  endfunction

  task automatic wait_fetch(input bit auto_step);
    int w = 0;
    while (!bus.fetch_req && w < 60) begin
      step_drv = auto_step;
      tick();
      w++;
    end
    step_drv = 0;
    if (!bus.fetch_req) chk("fetch_wait", bus.fetch_req, 1);
  endtask

  task automatic run_instr(input vec_t v, input bit auto_step, input bit mid_step,
                           output obs_t o);
    bit div = is_div(v);
    o = '{wb_off:-1, n_wb:0, n_clr:0, clr_off:-1, n_start:0, start_off:-1,
          n_req:0, lock_first:-1, n_lock:0, both:0, busy_gap:0, fetch_off:-1,
          we:0, load:0, to:0};
    wait_fetch(auto_step);
    bus.instr_valid = 1; bus.write_enable_in = v.we; bus.branch_select_in = v.br;
    bus.is_atc_in = v.atc; bus.alu_op_in = v.op; bus.cond_true = v.cond;
    bus.atc_flag = v.flag; bus.atc_gnt = 0;
    bus.alu_done = div ? 1'b0 : 1'($urandom);
    for (int k = 1; k <= T + 14; k++) begin
      tick();
      if (!bus.busy && o.wb_off < 0) o.busy_gap++;
      if (bus.reg_we) o.we = 1;
      if (bus.ip_inc && bus.ip_load) o.both++;
      if (bus.ip_inc || bus.ip_load) begin
        o.n_wb++;
        if (o.wb_off < 0) begin o.wb_off = k; o.load = bus.ip_load; end
      end
      if (bus.atc_clear) begin o.n_clr++; o.clr_off = k; end
      if (bus.alu_start) begin o.n_start++; o.start_off = k; end
      if (bus.atc_req) o.n_req++;
      if (bus.atc_lock) begin o.n_lock++; if (o.lock_first < 0) o.lock_first = k; end
      if (o.wb_off >= 0 && k == o.wb_off + 1) begin
        if (bus.fetch_req) o.fetch_off = k;
        break;
      end
      bus.instr_valid = 0;
      if (k == 2) begin  // decoder moves on; only the latched copy may matter
        bus.write_enable_in = 1'($urandom); bus.branch_select_in = 1'($urandom);
        bus.is_atc_in = 1'($urandom); bus.alu_op_in = 5'($urandom);
      end
      step_drv = mid_step && (k == 2);
      bus.alu_done = div ? (k == 2 + v.d) : 1'($urandom);
      bus.atc_gnt  = v.atc && (k >= 2 + v.g);
    end
    o.to = bus.alu_timeout;
    step_drv = 0;
    clr_inputs();
  endtask

  task automatic compare(input vec_t v, input obs_t o, input int exp_fetch);
    bit div = is_div(v);
    chk({v.name, ".wb_cycle"}, o.wb_off, v.e_off);
    chk({v.name, ".wb_count"}, o.n_wb, 1);
    chk({v.name, ".reg_we"}, o.we, v.e_we);
    chk({v.name, ".ip_load"}, o.load, v.e_load);
    chk({v.name, ".clear_count"}, o.n_clr, v.e_clr);
    chk({v.name, ".clear_cycle"}, o.clr_off, v.e_clr ? v.e_off - 1 : -1);
    chk({v.name, ".start_count"}, o.n_start, div);
    chk({v.name, ".start_cycle"}, o.start_off, div ? 2 : -1);
    chk({v.name, ".req_cycles"}, o.n_req, v.atc ? v.g + 1 : 0);
    chk({v.name, ".lock_first"}, o.lock_first, v.atc ? 3 + v.g : -1);
    chk({v.name, ".lock_cycles"}, o.n_lock, v.atc ? v.e_off - 2 - v.g : 0);
    chk({v.name, ".inc_and_load"}, o.both, 0);
    chk({v.name, ".busy_gap"}, o.busy_gap, 0);
    chk({v.name, ".alu_timeout"}, o.to, v.e_to);
    chk({v.name, ".fetch_again"}, o.fetch_off, exp_fetch);
  endtask

  vec_t tbl[12];
  vec_t v;
  obs_t o;
  logic sticky;
  int   cnt;

  initial begin
    //             name       we br at op       cond flag d   g  off we ld clr to
    tbl[0]  = mk("mov",      1, 0, 0, 5'h01,  0,  0,   0,  0, 3,  1, 0, 0, 0);
    tbl[1]  = mk("jmp_t",    1, 1, 0, 5'h02,  1,  0,   0,  0, 3,  0, 1, 0, 0);
    tbl[2]  = mk("jmp_n",    1, 1, 0, 5'h02,  0,  0,   0,  0, 3,  0, 0, 0, 0);
    tbl[3]  = mk("nowr",     0, 0, 0, 5'h03,  1,  0,   0,  0, 3,  0, 0, 0, 0);
    tbl[4]  = mk("udv_d5",   1, 0, 0, ALU_UDV,0,  0,   5,  0, 8,  1, 0, 0, 0);
    tbl[5]  = mk("sdv_d0",   1, 0, 0, ALU_SDV,0,  0,   0,  0, 3,  1, 0, 0, 0);
    tbl[6]  = mk("atc_g0f1", 0, 0, 1, 5'h00,  0,  1,   0,  0, 5,  0, 1, 1, 0);
    tbl[7]  = mk("atc_g0f0", 0, 0, 1, 5'h00,  0,  0,   0,  0, 4,  0, 0, 0, 0);
    tbl[8]  = mk("atc_g2f1", 1, 0, 1, 5'h00,  0,  1,   0,  2, 7,  0, 1, 1, 0);
    tbl[9]  = mk("atc_g2f0", 1, 0, 1, 5'h00,  0,  0,   0,  2, 6,  0, 0, 0, 0);
    tbl[10] = mk("sdv_dT",   1, 0, 0, ALU_SDV,0,  0,   T,  0, 11, 1, 0, 0, 0);
    tbl[11] = mk("udv_to",   1, 0, 0, ALU_UDV,0,  0,  99,  0, 11, 0, 0, 0, 1);

    reset = 1; step_drv = 0; clr_inputs();
    tick(); tick();
    chk("reset_outputs", outs(), 0);
    reset = 0;
    tick();
    chk("post_reset_fetch_req", bus.fetch_req, !STEP_MODE);
    chk("post_reset_busy", bus.busy, 0);

    foreach (tbl[i]) begin
      run_instr(tbl[i], 1, 0, o);
      compare(tbl[i], o, STEP_MODE ? -1 : tbl[i].e_off + 1);
    end

    // reset while in ATC_TEST: everything drops, no clear ever issued
    wait_fetch(1);
    bus.instr_valid = 1; bus.is_atc_in = 1; bus.atc_flag = 1; bus.atc_gnt = 1;
    tick(); bus.instr_valid = 0;
    tick(); chk("rst_atc_req", bus.atc_req, 1);
    tick(); chk("rst_atc_lock", bus.atc_lock, 1);
    reset = 1;
    tick(); chk("rst_mid_outputs", outs(), 0);
    reset = 0;
    tick();
    chk("rst_mid_fetch_req", bus.fetch_req, !STEP_MODE);
    chk("rst_mid_busy", bus.busy, 0);
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      if (bus.atc_clear || bus.atc_lock) cnt++;
      tick();
    end
    chk("rst_mid_no_clear", cnt, 0);
    clr_inputs();

    // reset and instr_valid together: reset wins, nothing is decoded
    reset = 1; bus.instr_valid = 1; bus.write_enable_in = 1;
    tick();
    reset = 0; bus.instr_valid = 0; bus.write_enable_in = 0;
    tick(); chk("rst_vs_valid_busy0", bus.busy, 0);
    tick(); chk("rst_vs_valid_busy1", bus.busy, 0);

`ifdef SEQ_SINGLE_STEP_EN
    do_reset();
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      if (bus.fetch_req) cnt++;
      tick();
    end
    chk("step_idle_no_fetch", cnt, 0);
    v = model(mk("step1", 1, 0, 0, 5'h01, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    run_instr(v, 1, 1, o);
    compare(v, o, v.e_off + 1);
    v.name = "step2";
    run_instr(v, 0, 0, o);
    compare(v, o, -1);
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      if (bus.fetch_req || bus.busy) cnt++;
      tick();
    end
    chk("step_stall_after_two", cnt, 0);
`endif

    do_reset();
    sticky = 0;
    for (int n = 0; n < 150; n++) begin
      int kind = $urandom_range(0, 3);
      v = mk($sformatf("rnd%0d", n), 1'($urandom), 1'($urandom), 0, 5'($urandom),
             1'($urandom), 1'($urandom), $urandom_range(0, T + 2),
             $urandom_range(0, 3), 0, 0, 0, 0, 0);
      if (kind == 0) v.atc = 1;
      else if (kind == 1) begin v.op = v.we ? ALU_UDV : ALU_SDV; v.br = 0; end
      else if (v.op == ALU_UDV || v.op == ALU_SDV) v.op = 5'h00;
      v = model(v);
      sticky = sticky | v.e_to;
      v.e_to = sticky;
      run_instr(v, 1, 0, o);
      compare(v, o, STEP_MODE ? -1 : v.e_off + 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
